// File: rtl/result_scoreboard.sv
// Scores one-hot argmax results against ground-truth labels over a run of NUM_SAMPLES samples.
// Latency: pred_idx/hit/pred_valid and the counters update on the accept edge (1 cycle).
// Backpressure: ready only in RUN, and it drops immediately after the final accept.
// Ports: clk, rst (async active-low); start pulse; maxi/maxi_valid/label sample input;
//        ready/busy/done status; pred_idx/pred_valid/hit per-sample result;
//        correct_cnt/sample_cnt run counters; onehot_err sticky malformed-input flag.
module result_scoreboard #(
   parameter int NUM_CLASSES = 10,
   parameter int NUM_SAMPLES = 750,
   parameter int CNT_W       = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [NUM_CLASSES-1:0] maxi,
   input  logic                   maxi_valid,
   input  logic [3:0]             label,
   output logic                   ready,
   output logic [3:0]             pred_idx,
   output logic                   pred_valid,
   output logic                   hit,
   output logic [CNT_W-1:0]       correct_cnt,
   output logic [CNT_W-1:0]       sample_cnt,
   output logic                   onehot_err,
   output logic                   busy,
   output logic                   done
);

   // Elaboration-time sanity checks on the parameter set.
   if (NUM_CLASSES != 10) begin : g_bad_classes
      $error("result_scoreboard: encoder supports exactly 10 classes");
   end
   if ((NUM_SAMPLES < 1) || (NUM_SAMPLES > ((1 << CNT_W) - 1))) begin : g_bad_samples
      $error("result_scoreboard: NUM_SAMPLES must fit in CNT_W bits");
   end

   localparam logic [CNT_W-1:0]       LAST_CNT = CNT_W'(NUM_SAMPLES);
   localparam logic [NUM_CLASSES-1:0] ONE      = {{(NUM_CLASSES-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t state;
   state_t state_nxt;

   logic       accept;
   logic       clear;
   logic [3:0] enc_idx;
   logic       enc_bad;
   logic       enc_hit;

   // Lowest set bit wins: scan from the top so lower indices overwrite.
   always_comb begin
      enc_idx = 4'hF;
      for (int i = NUM_CLASSES - 1; i >= 0; i--) begin
         if (maxi[i]) begin
            enc_idx = 4'(i);
         end
      end
   end

   // Malformed if empty, or if clearing the lowest set bit leaves anything behind.
   assign enc_bad = (maxi == '0) || ((maxi & (maxi - ONE)) != '0);

   // Labels 10..15 can never match, even against the 4'hF produced by an empty input.
   assign enc_hit = (enc_idx == label) && (label <= 4'd9);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and status outputs.
   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      clear     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               clear     = 1'b1;
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            // Once the final sample has been counted, refuse further samples while
            // the state machine steps to DONE, so a held maxi_valid cannot over-count.
            ready = (sample_cnt != LAST_CNT);
            if (sample_cnt == LAST_CNT) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            done = 1'b1;
            if (start) begin
               clear     = 1'b1;
               state_nxt = S_RUN;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign accept = maxi_valid && ready;

   // Per-sample result registers and run counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pred_idx    <= 4'h0;
         pred_valid  <= 1'b0;
         hit         <= 1'b0;
         correct_cnt <= '0;
         sample_cnt  <= '0;
         onehot_err  <= 1'b0;
      end else begin
         pred_valid <= accept;
         if (clear) begin
            // ready is low outside RUN, so a sample arriving with start is never accepted.
            correct_cnt <= '0;
            sample_cnt  <= '0;
            onehot_err  <= 1'b0;
         end else if (accept) begin
            pred_idx   <= enc_idx;
            hit        <= enc_hit;
            sample_cnt <= sample_cnt + 1'b1;
            if (enc_hit) begin
               correct_cnt <= correct_cnt + 1'b1;
            end
            if (enc_bad) begin
               onehot_err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_result_scoreboard.sv
// Self-checking bench for result_scoreboard with a 4-sample run.
// Expected per-sample results are queued when a sample is driven and popped when pred_valid is seen.
// Inputs are driven 1 time unit after the rising edge; outputs are checked at the same point.
module tb_result_scoreboard;

   localparam int NS = 4;
   localparam int CW = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [9:0]    maxi = '0;
   logic          maxi_valid = 1'b0;
   logic [3:0]    label = '0;
   logic          ready;
   logic [3:0]    pred_idx;
   logic          pred_valid;
   logic          hit;
   logic [CW-1:0] correct_cnt;
   logic [CW-1:0] sample_cnt;
   logic          onehot_err;
   logic          busy;
   logic          done;

   int checks = 0;
   int fails  = 0;
   logic [4:0] exp_q[$];
   logic [4:0] e;

   result_scoreboard #(
      .NUM_CLASSES(10),
      .NUM_SAMPLES(NS),
      .CNT_W(CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .maxi(maxi),
      .maxi_valid(maxi_valid),
      .label(label),
      .ready(ready),
      .pred_idx(pred_idx),
      .pred_valid(pred_valid),
      .hit(hit),
      .correct_cnt(correct_cnt),
      .sample_cnt(sample_cnt),
      .onehot_err(onehot_err),
      .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   // Drive one sample for one edge and queue its expected {pred_idx, hit}.
   task automatic send(input logic [9:0] m, input logic [3:0] l, input logic [3:0] ei, input logic eh);
      maxi       = m;
      label      = l;
      maxi_valid = 1'b1;
      exp_q.push_back({ei, eh});
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic test_reset();
      logic [9:0] tm[3] = '{10'h001, 10'h002, 10'h008};
      logic [3:0] tl[3] = '{4'd0, 4'd1, 4'd3};
      logic [3:0] ti[3] = '{4'd0, 4'd1, 4'd3};
      logic       all_out;
      rst = 1'b0;
      #3;
      checks++;
      if ({ready, busy, done, pred_valid, hit, pred_idx, onehot_err, correct_cnt, sample_cnt} !== '0) begin
         fails++;
         $display("FAIL reset_state: outputs=%h expected all zero",
                  {ready, busy, done, pred_valid, hit, pred_idx, onehot_err, correct_cnt, sample_cnt});
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      // maxi_valid in IDLE is dropped
      maxi = 10'h004; label = 4'd2; maxi_valid = 1'b1;
      @(posedge clk);
      #1;
      maxi_valid = 1'b0;
      checks++;
      if (pred_valid !== 1'b0 || sample_cnt !== '0 || ready !== 1'b0) begin
         fails++;
         $display("FAIL idle_drop: pred_valid=%b sample_cnt=%0d ready=%b expected 0/0/0", pred_valid, sample_cnt, ready);
      end
      pulse_start();
      checks++;
      if (ready !== 1'b1 || busy !== 1'b1) begin
         fails++;
         $display("FAIL start_run: ready=%b busy=%b expected 1/1", ready, busy);
      end
      for (int i = 0; i < 3; i++) begin
         send(tm[i], tl[i], ti[i], 1'b1);
         e = exp_q.pop_front();
         checks++;
         if (pred_valid !== 1'b1 || {pred_idx, hit} !== e) begin
            fails++;
            $display("FAIL reset_run_sample%0d: pv=%b idx=%h hit=%b expected pv=1 idx=%h hit=%b",
                     i, pred_valid, pred_idx, hit, e[4:1], e[0]);
         end
      end
      maxi_valid = 1'b0;
      checks++;
      if (sample_cnt !== CW'(3)) begin
         fails++;
         $display("FAIL reset_pre_count: sample_cnt=%0d expected 3", sample_cnt);
      end
      // Assert reset between edges; outputs must clear before the next edge.
      #2;
      rst = 1'b0;
      #1;
      all_out = |{ready, busy, done, pred_valid, hit, pred_idx, onehot_err, correct_cnt, sample_cnt};
      checks++;
      if (all_out !== 1'b0) begin
         fails++;
         $display("FAIL async_reset: outputs=%h expected all zero",
                  {ready, busy, done, pred_valid, hit, pred_idx, onehot_err, correct_cnt, sample_cnt});
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL reset_idle: ready=%b busy=%b done=%b expected 0/0/0", ready, busy, done);
      end
   endtask

   task automatic test_back_to_back();
      logic [9:0] tm[4] = '{10'h004, 10'h200, 10'h001, 10'h010};
      logic [3:0] tl[4] = '{4'd2, 4'd9, 4'd3, 4'd4};
      logic [3:0] ti[4] = '{4'd2, 4'd9, 4'd0, 4'd4};
      logic       th[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      pulse_start();
      checks++;
      if (correct_cnt !== '0 || sample_cnt !== '0 || ready !== 1'b1) begin
         fails++;
         $display("FAIL b2b_start: correct=%0d samples=%0d ready=%b expected 0/0/1", correct_cnt, sample_cnt, ready);
      end
      for (int i = 0; i < 4; i++) begin
         send(tm[i], tl[i], ti[i], th[i]);
         e = exp_q.pop_front();
         checks++;
         if (pred_valid !== 1'b1 || {pred_idx, hit} !== e) begin
            fails++;
            $display("FAIL b2b_sample%0d: pv=%b idx=%h hit=%b expected pv=1 idx=%h hit=%b",
                     i, pred_valid, pred_idx, hit, e[4:1], e[0]);
         end
      end
      checks++;
      if (correct_cnt !== CW'(3) || sample_cnt !== CW'(4) || ready !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL b2b_final: correct=%0d samples=%0d ready=%b done=%b expected 3/4/0/0",
                  correct_cnt, sample_cnt, ready, done);
      end
      // maxi_valid still held: the extra sample must not be counted.
      @(posedge clk);
      #1;
      maxi_valid = 1'b0;
      checks++;
      if (pred_valid !== 1'b0 || sample_cnt !== CW'(4) || done !== 1'b1 || busy !== 1'b0 || onehot_err !== 1'b0) begin
         fails++;
         $display("FAIL b2b_done: pv=%b samples=%0d done=%b busy=%b err=%b expected 0/4/1/0/0",
                  pred_valid, sample_cnt, done, busy, onehot_err);
      end
   endtask

   task automatic test_ignore_in_done();
      maxi = 10'h002; label = 4'd1; maxi_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (pred_valid !== 1'b0 || correct_cnt !== CW'(3) || sample_cnt !== CW'(4) || done !== 1'b1) begin
            fails++;
            $display("FAIL done_drop%0d: pv=%b correct=%0d samples=%0d done=%b expected 0/3/4/1",
                     i, pred_valid, correct_cnt, sample_cnt, done);
         end
      end
      maxi_valid = 1'b0;
   endtask

   task automatic test_restart();
      maxi = 10'h004; label = 4'd2; maxi_valid = 1'b1;
      pulse_start();
      maxi_valid = 1'b0;
      checks++;
      if (correct_cnt !== '0 || sample_cnt !== '0 || onehot_err !== 1'b0 || ready !== 1'b1 ||
          pred_valid !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL restart: correct=%0d samples=%0d err=%b ready=%b pv=%b done=%b expected 0/0/0/1/0/0",
                  correct_cnt, sample_cnt, onehot_err, ready, pred_valid, done);
      end
   endtask

   task automatic test_onehot_err();
      send(10'h000, 4'd0, 4'hF, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (pred_valid !== 1'b1 || {pred_idx, hit} !== e || onehot_err !== 1'b1) begin
         fails++;
         $display("FAIL onehot_zero: pv=%b idx=%h hit=%b err=%b expected pv=1 idx=%h hit=%b err=1",
                  pred_valid, pred_idx, hit, onehot_err, e[4:1], e[0]);
      end
      send(10'h012, 4'd1, 4'd1, 1'b1);
      e = exp_q.pop_front();
      maxi_valid = 1'b0;
      checks++;
      if (pred_valid !== 1'b1 || {pred_idx, hit} !== e || onehot_err !== 1'b1) begin
         fails++;
         $display("FAIL onehot_multi: pv=%b idx=%h hit=%b err=%b expected pv=1 idx=%h hit=%b err=1",
                  pred_valid, pred_idx, hit, onehot_err, e[4:1], e[0]);
      end
      checks++;
      if (sample_cnt !== CW'(2) || correct_cnt !== CW'(1)) begin
         fails++;
         $display("FAIL onehot_counts: samples=%0d correct=%0d expected 2/1", sample_cnt, correct_cnt);
      end
   endtask

   task automatic test_bad_label();
      send(10'h004, 4'd12, 4'd2, 1'b0);
      e = exp_q.pop_front();
      maxi_valid = 1'b0;
      checks++;
      if (pred_valid !== 1'b1 || {pred_idx, hit} !== e || sample_cnt !== CW'(3) || correct_cnt !== CW'(1)) begin
         fails++;
         $display("FAIL bad_label: pv=%b idx=%h hit=%b samples=%0d correct=%0d expected 1/%h/%b/3/1",
                  pred_valid, pred_idx, hit, sample_cnt, correct_cnt, e[4:1], e[0]);
      end
      @(posedge clk);
      #1;
      send(10'h3FF, 4'd0, 4'd0, 1'b1);
      e = exp_q.pop_front();
      maxi_valid = 1'b0;
      checks++;
      if ({pred_idx, hit} !== e || sample_cnt !== CW'(4) || correct_cnt !== CW'(2)) begin
         fails++;
         $display("FAIL last_sample: idx=%h hit=%b samples=%0d correct=%0d expected %h/%b/4/2",
                  pred_idx, hit, sample_cnt, correct_cnt, e[4:1], e[0]);
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b1 || onehot_err !== 1'b1) begin
         fails++;
         $display("FAIL run2_done: done=%b err=%b expected 1/1", done, onehot_err);
      end
      pulse_start();
      checks++;
      if (onehot_err !== 1'b0 || sample_cnt !== '0 || correct_cnt !== '0 || ready !== 1'b1) begin
         fails++;
         $display("FAIL err_clear: err=%b samples=%0d correct=%0d ready=%b expected 0/0/0/1",
                  onehot_err, sample_cnt, correct_cnt, ready);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_ignore_in_done();
      test_restart();
      test_onehot_err();
      test_bad_label();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
